debug_bus_arbiter: RTL and testbench
====================================

DEBUG_BUS_ARBITER -- requirements
Module: debug_bus_arbiter

Interface
REQ-001 SHALL have parameter HALT_TIMEOUT, default 16, meaning the number of DRAIN cycles before forced halt (used only with DBG_ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dbg_op_req_i  input  1  debug module memory access request (level).
REQ-005 SHALL have port dbg_halt_req_i  input  1  debugger halt request (level).
REQ-006 SHALL have port dbg_reset_req_i  input  1  debugger core reset request (level).
REQ-007 SHALL have port dbg_we_i  input  1  debug write enable.
REQ-008 SHALL have port dbg_addr_i  input  32  debug address.
REQ-009 SHALL have port dbg_wdata_i  input  32  debug write data.
REQ-010 SHALL have port dbg_gnt_o  output  1  debug owns bus (state HALTED).
REQ-011 SHALL have port core_req_i  input  1  core memory request.
REQ-012 SHALL have port core_we_i  input  1  core write enable.
REQ-013 SHALL have port core_addr_i  input  32  core address.
REQ-014 SHALL have port core_wdata_i  input  32  core write data.
REQ-015 SHALL have port core_gnt_o  output  1  core request accepted this cycle.
REQ-016 SHALL have port core_idle_i  input  1  core pipeline drained, no outstanding access.
REQ-017 SHALL have port hold_o  output  1  stall core pipeline.
REQ-018 SHALL have port core_rst_o  output  1  core reset request.
REQ-019 SHALL have ports bus_req_o/bus_we_o (1), bus_addr_o/bus_wdata_o (32), outputs to shared memory bus.
REQ-020 SHALL have port bus_rdata_i  input  32  bus read data, fanned to rdata_o.
REQ-021 SHALL have port rdata_o  output  32  equals bus_rdata_i, valid for current owner.
REQ-022 SHALL have port timeout_o  output  1  sticky forced-halt flag.

Function
REQ-023 SHALL implement registered FSM states IDLE, DRAIN, HALTED, RELEASE, RESET; outputs decoded combinationally from state.
REQ-024 IDLE: core owns bus; bus_* = core_*; core_gnt_o = core_req_i; hold_o=0; dbg_gnt_o=0.
REQ-025 IDLE -> DRAIN when dbg_op_req_i or dbg_halt_req_i is 1.
REQ-026 DRAIN: hold_o=1; core still owns bus; -> HALTED when core_idle_i=1 and core_req_i=0 in same cycle.
REQ-027 HALTED: hold_o=1; dbg_gnt_o=1; core_gnt_o=0; bus_req_o=dbg_op_req_i; bus_we/addr/wdata = dbg_*.
REQ-028 HALTED -> RELEASE when dbg_op_req_i=0 and dbg_halt_req_i=0; else stay (back-to-back debug ops need no re-halt).
REQ-029 RELEASE: one cycle, hold_o=0, bus_req_o=0, core_gnt_o=0; -> IDLE unconditionally.
REQ-030 dbg_reset_req_i=1 from any state SHALL transition to RESET next cycle (highest priority).
REQ-031 RESET: core_rst_o=1, hold_o=0, bus_req_o=0, both grants 0; -> IDLE when dbg_reset_req_i=0.
REQ-032 Grant latency: debug access reaches bus no earlier than 2 cycles after request (IDLE->DRAIN->HALTED).
REQ-033 Request reaching DRAIN that drops before halt SHALL still complete halt then release via HALTED->RELEASE.
REQ-034 bus_req_o SHALL never be driven by both owners; ownership changes only on state transition.

Reset
REQ-035 rst_n=0 SHALL asynchronously force state IDLE, timeout counter 0, timeout_o=0.
REQ-036 During reset outputs: hold_o=0, core_rst_o=0, dbg_gnt_o=0, core_gnt_o=core_req_i, bus_* = core_*.

Configuration
REQ-037 With DBG_ARB_TIMEOUT_EN defined: counter clears on DRAIN entry, increments each DRAIN cycle; at HALT_TIMEOUT cycles -> HALTED and timeout_o set, cleared only by rst_n.
REQ-038 Without DBG_ARB_TIMEOUT_EN: DRAIN waits indefinitely for core_idle_i; no counter; timeout_o tied 0.

Verification
REQ-039 core_req_i=1, addr 0x100, no debug -> bus_addr_o=0x100, core_gnt_o=1, hold_o=0.
REQ-040 dbg_op_req_i=1, core_idle_i=1 -> hold_o=1 at cycle 1, dbg_gnt_o=1 and bus_addr_o=dbg_addr_i at cycle 2.
REQ-041 In HALTED drop both requests -> RELEASE one cycle (hold_o=0, bus_req_o=0), IDLE next.
REQ-042 dbg_reset_req_i=1 in HALTED -> core_rst_o=1, hold_o=0 next cycle; release -> IDLE.
REQ-043 Macro on, HALT_TIMEOUT=16, core_idle_i=0 -> HALTED after 16 DRAIN cycles, timeout_o=1; macro off -> remains DRAIN.
REQ-044 rst_n low mid-HALTED -> immediately IDLE, hold_o=0, dbg_gnt_o=0.

Source files
------------

// File: rtl/debug_bus_arbiter.sv
// Debug/core arbiter for the shared memory bus: the core is halted before the debugger takes the bus.
// Optional forced-halt timeout in DRAIN, enabled by defining DBG_ARB_TIMEOUT_EN.
module debug_bus_arbiter #(
    parameter int HALT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dbg_op_req_i,
    input  logic        dbg_halt_req_i,
    input  logic        dbg_reset_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    input  logic        core_idle_i,
    output logic        hold_o,
    output logic        core_rst_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] rdata_o,
    output logic        timeout_o
);

    // state   | meaning
    // IDLE    | core owns the bus, no debug activity
    // DRAIN   | core stalled, waiting for its pipeline to empty
    // HALTED  | debugger owns the bus
    // RELEASE | one dead cycle while ownership returns to the core
    // RESET   | debugger holds the core in reset
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_HALTED  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RESET   = 3'd4
    } state_t;

    state_t state, state_nxt;
    logic   drain_force;

    if (HALT_TIMEOUT < 1) begin : g_bad_halt_timeout
        $error("HALT_TIMEOUT must be at least 1");
    end

`ifdef DBG_ARB_TIMEOUT_EN
    localparam int CNT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    logic [CNT_W-1:0] drain_cnt;
    logic             timeout_q;

    // Counter sits at zero outside DRAIN, so it is already cleared on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_DRAIN && !drain_force) drain_cnt <= drain_cnt + 1'b1;
            else                                   drain_cnt <= '0;
            if (drain_force && !dbg_reset_req_i)   timeout_q <= 1'b1;
        end
    end

    // A core that drains naturally on the last cycle is not a timeout.
    assign drain_force = (state == ST_DRAIN) && (drain_cnt == CNT_LAST) &&
                         !(core_idle_i && !core_req_i);
    assign timeout_o   = timeout_q;
`else
    assign drain_force = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (dbg_reset_req_i) begin
            state_nxt = ST_RESET;
        end else begin
            case (state)
                ST_IDLE:    if (dbg_op_req_i || dbg_halt_req_i) state_nxt = ST_DRAIN;
                ST_DRAIN:   if ((core_idle_i && !core_req_i) || drain_force) state_nxt = ST_HALTED;
                ST_HALTED:  if (!dbg_op_req_i && !dbg_halt_req_i) state_nxt = ST_RELEASE;
                ST_RELEASE: state_nxt = ST_IDLE;
                ST_RESET:   state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Bus ownership is a pure decode of the registered state.
    always_comb begin
        hold_o      = 1'b0;
        core_rst_o  = 1'b0;
        dbg_gnt_o   = 1'b0;
        core_gnt_o  = 1'b0;
        bus_req_o   = 1'b0;
        bus_we_o    = core_we_i;
        bus_addr_o  = core_addr_i;
        bus_wdata_o = core_wdata_i;
        case (state)
            ST_IDLE: begin
                core_gnt_o = core_req_i;
                bus_req_o  = core_req_i;
            end
            ST_DRAIN: begin
                hold_o     = 1'b1;
                core_gnt_o = core_req_i;
                bus_req_o  = core_req_i;
            end
            ST_HALTED: begin
                hold_o      = 1'b1;
                dbg_gnt_o   = 1'b1;
                bus_req_o   = dbg_op_req_i;
                bus_we_o    = dbg_we_i;
                bus_addr_o  = dbg_addr_i;
                bus_wdata_o = dbg_wdata_i;
            end
            ST_RELEASE: begin
                bus_we_o = 1'b0;
            end
            ST_RESET: begin
                core_rst_o = 1'b1;
                bus_we_o   = 1'b0;
            end
            default: begin
                core_gnt_o = core_req_i;
                bus_req_o  = core_req_i;
            end
        endcase
    end

    assign rdata_o = bus_rdata_i;

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Directed bench for debug_bus_arbiter; expectations follow DBG_ARB_TIMEOUT_EN when defined.
module tb_debug_bus_arbiter;

`ifdef DBG_ARB_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dbg_op_req_i = 1'b0, dbg_halt_req_i = 1'b0, dbg_reset_req_i = 1'b0, dbg_we_i = 1'b0;
    logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
    logic        dbg_gnt_o;
    logic        core_req_i = 1'b0, core_we_i = 1'b0, core_idle_i = 1'b0;
    logic [31:0] core_addr_i = '0, core_wdata_i = '0;
    logic        core_gnt_o, hold_o, core_rst_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic [31:0] rdata_o;
    logic        timeout_o;

    int n_total = 0;
    int n_bad   = 0;

    debug_bus_arbiter #(.HALT_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_op_req_i(dbg_op_req_i), .dbg_halt_req_i(dbg_halt_req_i),
        .dbg_reset_req_i(dbg_reset_req_i), .dbg_we_i(dbg_we_i),
        .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_idle_i(core_idle_i),
        .hold_o(hold_o), .core_rst_o(core_rst_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .rdata_o(rdata_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset behaviour: core passes straight through
        core_req_i = 1'b1; core_addr_i = 32'h100; core_wdata_i = 32'hC0DE_0001; core_we_i = 1'b1;
        #12;
        chk("rst_hold", hold_o, 0);
        chk("rst_dbg_gnt", dbg_gnt_o, 0);
        chk("rst_core_rst", core_rst_o, 0);
        chk("rst_core_gnt", core_gnt_o, 1);
        chk("rst_bus_addr", bus_addr_o, 32'h100);
        chk("rst_timeout", timeout_o, 0);
        rst_n = 1'b1;
        tick();

        // core access in IDLE
        chk("idle_bus_addr", bus_addr_o, 32'h100);
        chk("idle_bus_wdata", bus_wdata_o, 32'hC0DE_0001);
        chk("idle_bus_req", bus_req_o, 1);
        chk("idle_core_gnt", core_gnt_o, 1);
        chk("idle_hold", hold_o, 0);
        core_req_i = 1'b0; #1;
        chk("idle_noreq_gnt", core_gnt_o, 0);
        chk("idle_noreq_bus", bus_req_o, 0);

        // debug op with idle core: DRAIN at cycle 1, HALTED at cycle 2
        core_idle_i = 1'b1; dbg_op_req_i = 1'b1; dbg_we_i = 1'b1;
        dbg_addr_i = 32'hDEAD_0000; dbg_wdata_i = 32'h5A5A_A5A5; #1;
        chk("c0_hold", hold_o, 0);
        tick();
        chk("c1_hold", hold_o, 1);
        chk("c1_dbg_gnt", dbg_gnt_o, 0);
        chk("c1_bus_addr", bus_addr_o, 32'h100);
        tick();
        chk("c2_dbg_gnt", dbg_gnt_o, 1);
        chk("c2_bus_addr", bus_addr_o, 32'hDEAD_0000);
        chk("c2_bus_wdata", bus_wdata_o, 32'h5A5A_A5A5);
        chk("c2_bus_we", bus_we_o, 1);
        chk("c2_bus_req", bus_req_o, 1);
        core_req_i = 1'b1; bus_rdata_i = 32'h1234_5678; #1;
        chk("halt_core_gnt", core_gnt_o, 0);
        chk("halt_rdata", rdata_o, 32'h1234_5678);

        // back-to-back: halt held, op dropped -> stay HALTED, bus idle
        dbg_op_req_i = 1'b0; dbg_halt_req_i = 1'b1; #1;
        chk("b2b_bus_req", bus_req_o, 0);
        tick();
        chk("b2b_dbg_gnt", dbg_gnt_o, 1);

        // release: one dead cycle then IDLE
        dbg_halt_req_i = 1'b0;
        tick();
        chk("rel_hold", hold_o, 0);
        chk("rel_bus_req", bus_req_o, 0);
        chk("rel_core_gnt", core_gnt_o, 0);
        chk("rel_dbg_gnt", dbg_gnt_o, 0);
        tick();
        chk("rel_idle_gnt", core_gnt_o, 1);
        chk("rel_idle_bus", bus_req_o, 1);

        // request dropped during DRAIN still halts then releases
        core_req_i = 1'b0; core_idle_i = 1'b0; dbg_halt_req_i = 1'b1;
        tick();
        chk("drop_drain_hold", hold_o, 1);
        dbg_halt_req_i = 1'b0;
        tick();
        chk("drop_wait_hold", hold_o, 1);
        chk("drop_wait_gnt", dbg_gnt_o, 0);
        core_idle_i = 1'b1;
        tick();
        chk("drop_halted", dbg_gnt_o, 1);
        tick();
        chk("drop_release", hold_o, 0);
        tick();

        // debugger reset from HALTED
        dbg_halt_req_i = 1'b1;
        tick(); tick();
        chk("pre_rst_gnt", dbg_gnt_o, 1);
        dbg_reset_req_i = 1'b1; core_req_i = 1'b1;
        tick();
        chk("dbgrst_core_rst", core_rst_o, 1);
        chk("dbgrst_hold", hold_o, 0);
        chk("dbgrst_dbg_gnt", dbg_gnt_o, 0);
        chk("dbgrst_core_gnt", core_gnt_o, 0);
        chk("dbgrst_bus_req", bus_req_o, 0);
        tick();
        chk("dbgrst_held", core_rst_o, 1);
        dbg_reset_req_i = 1'b0; dbg_halt_req_i = 1'b0;
        tick();
        chk("dbgrst_exit", core_rst_o, 0);
        chk("dbgrst_idle_gnt", core_gnt_o, 1);

        // core never drains: timeout behaviour depends on the build
        core_req_i = 1'b0; core_idle_i = 1'b0; dbg_halt_req_i = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to_15_gnt", dbg_gnt_o, 0);
        chk("to_15_flag", timeout_o, 0);
        tick();
        chk("to_16_gnt", dbg_gnt_o, {31'd0, TO_EN});
        chk("to_16_flag", timeout_o, {31'd0, TO_EN});
        chk("to_16_hold", hold_o, 1);
        for (int i = 0; i < 8; i++) tick();
        chk("to_late_gnt", dbg_gnt_o, {31'd0, TO_EN});

        core_idle_i = 1'b1;
        tick();
        chk("to_halted", dbg_gnt_o, 1);
        dbg_halt_req_i = 1'b0;
        tick(); tick();
        chk("to_sticky", timeout_o, {31'd0, TO_EN});

        // async reset in the middle of HALTED
        dbg_halt_req_i = 1'b1;
        tick(); tick();
        chk("pre_arst_gnt", dbg_gnt_o, 1);
        #2 rst_n = 1'b0; #1;
        chk("arst_hold", hold_o, 0);
        chk("arst_dbg_gnt", dbg_gnt_o, 0);
        chk("arst_timeout", timeout_o, 0);
        #10;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
